hamming_addr_dec: RTL and testbench

Pipelined, parametrised Hamming single-error-correcting decoder for address fields arriving from the front-end readout path, with optional Gray-to-binary conversion of the corrected payload. It sits between the hit-data deserialiser and the readout-control address consumers. It generalises the fixed 12-bit row decoder to any data width and adds a valid/ready handshake, error flags and optional error counters.

---
 rtl/hamming_addr_dec_pkg.sv | 49 ++++
 rtl/hamming_addr_dec_syndrome.sv | 16 +
 rtl/hamming_addr_dec.sv | 123 ++++++++++++
 tb/tb_hamming_addr_dec.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hamming_addr_dec_pkg.sv
// Shared Hamming SEC helpers: parity width, data bit placement, syndrome, Gray decode.
// Used by hamming_addr_dec and hamming_syndrome.
package hamming_pkg;

    localparam int MAX_CW = 31;
    localparam int SYN_W  = 5;

    typedef struct packed {
        logic corr;
        logic uncorr;
    } flags_t;

    function automatic int par_w(input int data_w);
        return (data_w <= 11) ? 4 : 5;
    endfunction

    // Hamming position (1-based) of data bit d; powers of two are parity slots.
    function automatic int data_pos(input int d);
        int cnt;
        int pos;
        cnt = -1;
        pos = 0;
        for (int p = 1; p <= MAX_CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                cnt++;
                if (cnt == d && pos == 0) pos = p;
            end
        end
        return pos;
    endfunction

    function automatic logic [SYN_W-1:0] syndrome(input logic [MAX_CW-1:0] cw);
        logic [SYN_W-1:0] s;
        s = '0;
        for (int i = 0; i < MAX_CW; i++)
            if (cw[i]) s ^= SYN_W'(i + 1);
        return s;
    endfunction

    // Input is zero-extended, so the MSB of the real field decodes as itself.
    function automatic logic [25:0] gray2bin(input logic [25:0] g);
        logic [25:0] b;
        b[25] = g[25];
        for (int i = 24; i >= 0; i--)
            b[i] = b[i + 1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/hamming_addr_dec_syndrome.sv
// Combinational Hamming syndrome: XOR of the 1-based positions of all set bits.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int CW_W = 12
) (
    input  logic [CW_W-1:0]  i_cw,
    output logic [SYN_W-1:0] o_syn
);

    logic [MAX_CW-1:0] w_cw_ext;

    assign w_cw_ext = MAX_CW'(i_cw);
    assign o_syn    = syndrome(w_cw_ext);

endmodule

// File: rtl/hamming_addr_dec.sv
// Two-stage Hamming SEC address decoder with optional Gray-to-binary output.
// Error counters are built only when HAMMING_ERRCNT_EN is defined.
module hamming_addr_dec
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int GRAY   = 1,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = par_w(DATA_W),
    localparam int CW_W   = DATA_W + PAR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CW_W-1:0]   in_cw,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corr,
    output logic              out_uncorr,
    output logic              out_valid,
    input  logic              out_ready
`ifdef HAMMING_ERRCNT_EN
   ,input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
`endif
);

    logic              w_s1_adv, w_s2_adv;
    logic [SYN_W-1:0]  w_syn;
    logic [DATA_W-1:0] w_in_dat, w_raw, w_dec;
    flags_t            w_flags;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_dat;
    logic [SYN_W-1:0]  r_s1_syn;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;
    flags_t            r_s2_flags;

    assign w_s2_adv = !r_s2_valid | out_ready;
    assign w_s1_adv = !r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv;

    hamming_syndrome #(.CW_W(CW_W)) u_syn (
        .i_cw  (in_cw),
        .o_syn (w_syn)
    );

    // Parity bits are fully summarised by the syndrome, so only data bits are staged.
    for (genvar d = 0; d < DATA_W; d++) begin : g_dat
        localparam int P = data_pos(d);
        assign w_in_dat[d] = in_cw[P-1];
        assign w_raw[d]    = r_s1_dat[d] ^ (r_s1_syn == SYN_W'(P));
    end

    always_comb begin
        w_flags        = '0;
        w_flags.corr   = (r_s1_syn != '0) && (int'(r_s1_syn) <= CW_W);
        w_flags.uncorr = int'(r_s1_syn) > CW_W;
        w_dec          = (GRAY != 0) ? DATA_W'(gray2bin(26'(w_raw))) : w_raw;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_dat   <= '0;
            r_s1_syn   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_dat <= w_in_dat;
                r_s1_syn <= w_syn;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_flags <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data  <= w_dec;
                r_s2_flags <= w_flags;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_data   = r_s2_data;
    assign out_corr   = r_s2_flags.corr;
    assign out_uncorr = r_s2_flags.uncorr;

`ifdef HAMMING_ERRCNT_EN
    logic             w_out_fire;
    logic [CNT_W-1:0] r_corr_cnt, r_uncorr_cnt;

    assign w_out_fire = r_s2_valid & out_ready;

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else begin
            if (w_out_fire && r_s2_flags.corr && r_corr_cnt != '1)
                r_corr_cnt <= r_corr_cnt + 1'b1;
            if (w_out_fire && r_s2_flags.uncorr && r_uncorr_cnt != '1)
                r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
        end
    end

    assign corr_cnt   = r_corr_cnt;
    assign uncorr_cnt = r_uncorr_cnt;
`endif

endmodule

// File: tb/tb_hamming_addr_dec.sv
// Directed bench for hamming_addr_dec: two instances (GRAY=0 / GRAY=1) share stimulus.
// Counter checks are compiled in when HAMMING_ERRCNT_EN is defined.
module tb_hamming_addr_dec;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] in_cw = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic        rdy0, corr0, unc0, vld0;
    logic [7:0]  dat0;
    logic        rdy1, corr1, unc1, vld1;
    logic [7:0]  dat1;
`ifdef HAMMING_ERRCNT_EN
    logic        cnt_clr = 1'b0;
    logic [1:0]  cc0, uc0;
    logic [15:0] cc1, uc1;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [11:0] bp_cw  [5] = '{12'h888, 12'h007, 12'h019, 12'h02A, 12'h000};
    logic [7:0]  bp_exp [5] = '{8'h80, 8'h01, 8'h02, 8'h04, 8'h00};
    logic [7:0]  rcv[$];
    int          sent;

    always #5 clk = ~clk;

    hamming_addr_dec #(.DATA_W(8), .GRAY(0), .CNT_W(2)) u0 (
        .clk(clk), .reset_n(reset_n), .in_cw(in_cw), .in_valid(in_valid), .in_ready(rdy0),
        .out_data(dat0), .out_corr(corr0), .out_uncorr(unc0), .out_valid(vld0), .out_ready(out_ready)
`ifdef HAMMING_ERRCNT_EN
       ,.cnt_clr(cnt_clr), .corr_cnt(cc0), .uncorr_cnt(uc0)
`endif
    );

    hamming_addr_dec #(.DATA_W(8), .GRAY(1), .CNT_W(16)) u1 (
        .clk(clk), .reset_n(reset_n), .in_cw(in_cw), .in_valid(in_valid), .in_ready(rdy1),
        .out_data(dat1), .out_corr(corr1), .out_uncorr(unc1), .out_valid(vld1), .out_ready(out_ready)
`ifdef HAMMING_ERRCNT_EN
       ,.cnt_clr(cnt_clr), .corr_cnt(cc1), .uncorr_cnt(uc1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one word for one cycle; returns at the negedge after acceptance.
    task automatic send(input logic [11:0] cw);
        @(negedge clk);
        in_cw    = cw;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        // reset state
        @(negedge clk);
        chk("rst_vld", 32'(vld0), 32'd0);
        chk("rst_data", 32'(dat0), 32'd0);
        chk("rst_flags", 32'({corr0, unc0}), 32'd0);
        chk("rst_in_ready", 32'(rdy0), 32'd1);
`ifdef HAMMING_ERRCNT_EN
        chk("rst_cnt", 32'({cc0, uc0}), 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // clean words, 2-cycle latency
        send(12'h000);
        chk("clean0_lat1", 32'(vld0), 32'd0);
        @(negedge clk);
        chk("clean0_vld", 32'(vld0), 32'd1);
        chk("clean0_data", 32'(dat0), 32'h00);
        chk("clean0_flags", 32'({corr0, unc0}), 32'd0);
        send(12'h007);
        chk("clean7_lat1", 32'(vld0), 32'd0);
        @(negedge clk);
        chk("clean7_vld", 32'(vld0), 32'd1);
        chk("clean7_data", 32'(dat0), 32'h01);
        chk("clean7_flags", 32'({corr0, unc0}), 32'd0);
        chk("clean7_gray", 32'(dat1), 32'h01);

        // single-bit correction (bit 5 flipped from 0x888)
        send(12'h8A8);
        @(negedge clk);
        chk("corr_vld", 32'(vld1), 32'd1);
        chk("corr_gray_data", 32'(dat1), 32'hFF);
        chk("corr_flag", 32'(corr1), 32'd1);
        chk("corr_unflag", 32'(unc1), 32'd0);
        chk("corr_bin_data", 32'(dat0), 32'h80);

        // uncorrectable, S=13
        send(12'h801);
        @(negedge clk);
        chk("unc_flag", 32'(unc0), 32'd1);
        chk("unc_corrflag", 32'(corr0), 32'd0);
        chk("unc_data", 32'(dat0), 32'h80);
        chk("unc_gray_data", 32'(dat1), 32'hFF);

        // backpressure: out_ready low for cycles 2..4
        repeat (3) @(negedge clk);
        sent = 0;
        for (int c = 0; c < 40 && rcv.size() < 5; c++) begin
            if (c > 0) @(negedge clk);
            out_ready = !(c >= 2 && c < 5);
            in_valid  = (sent < 5);
            in_cw     = bp_cw[(sent < 5) ? sent : 0];
            #1;
            if (c >= 2 && c < 5) begin
                chk("bp_in_ready_low", 32'(rdy0), 32'd0);
                chk("bp_hold_vld", 32'(vld0), 32'd1);
                chk("bp_hold_data", 32'(dat0), 32'h80);
            end
            if (vld0 && out_ready) rcv.push_back(dat0);
            if (in_valid && rdy0) sent++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 32'(rcv.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk("bp_order", (i < rcv.size()) ? 32'(rcv[i]) : 32'hDEAD, 32'(bp_exp[i]));
        repeat (2) @(negedge clk);
        chk("bp_no_dup", 32'(vld0), 32'd0);

        // reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        in_cw = 12'h8A8; in_valid = 1'b1;
        @(negedge clk);
        in_cw = 12'h007;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rstm_pre_vld", 32'(vld0), 32'd1);
        chk("rstm_pre_corr", 32'(corr0), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstm_vld", 32'(vld0), 32'd0);
        chk("rstm_data", 32'(dat0), 32'd0);
        chk("rstm_flags", 32'({corr0, unc0}), 32'd0);
        chk("rstm_in_ready", 32'(rdy0), 32'd1);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstm_no_stale", 32'(vld0), 32'd0);
        end

`ifdef HAMMING_ERRCNT_EN
        // counters: saturation, clear priority, uncorrected count
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_cw = 12'h8A8; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("cnt_sat", 32'(cc0), 32'd3);
        chk("cnt_unc0", 32'(uc0), 32'd0);
        send(12'h8A8);
        @(negedge clk);
        chk("cnt_clr_pre_vld", 32'(vld0), 32'd1);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("cnt_clr_prio", 32'(cc0), 32'd0);
        send(12'h801);
        repeat (2) @(negedge clk);
        chk("cnt_unc1", 32'(uc0), 32'd1);
        chk("cnt_corr_after", 32'(cc0), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
